pipelined_add_tree: RTL and testbench
=====================================

# pipelined_add_tree

Parametrised, pipelined reduction adder for the systolic array's partial-product path. Each beat sums N_IN lanes of IN_W bits, signed or unsigned, through a registered binary tree. An accumulator can chain several beats into one result, closed by `in_last`. Valid/ready handshakes on both sides allow the array drain logic to stall the tree without losing data.

## Interface
- `N_IN`, 12: number of input lanes, ≥2; padded internally with zero lanes to `2**LEVELS`.
- `IN_W`, 8: lane width in bits.
- `SIGNED`, 0: 1 = lanes are two's complement and are sign-extended; 0 = lanes are unsigned and zero-extended.
- `ACC_BITS`, 4: extra headroom bits for multi-beat accumulation.
- `LEVELS` (derived, localparam): `$clog2(N_IN)`.
- `OUT_W` (derived, localparam): `IN_W + LEVELS + ACC_BITS`. The defaults give 8+4+4 = 16.
- Ports:
  - `clk`  in  1  single clock; all logic is on the rising edge.
  - `rst_n`  in  1  synchronous, active-low reset.
  - `in_data`  in  N_IN*IN_W  packed lanes; lane i is `in_data[i*IN_W +: IN_W]`.
  - `in_valid`  in  1  beat present.
  - `in_last`  in  1  final beat of the accumulation group; sampled with the beat.
  - `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
  - `out_data`  out  OUT_W  group sum.
  - `out_valid`  out  1  `out_data` valid.
  - `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.

## Operation
- Extension: every lane is extended to OUT_W bits (sign- or zero-extended per `SIGNED`) before the first adder level.
- Tree structure:
  - Level k (k = 1..LEVELS) adds pairs from level k-1 and registers the results.
  - Each level carries a valid bit and a last bit alongside its data.
  - The padded zero lanes take no part in the arithmetic result.
- Accumulate stage, after level LEVELS, holding register `acc`:
  - Beat with last=0: `acc <= acc + S`, where S is the beat's tree sum. No output is produced.
  - Beat with last=1: `out_data <= acc + S`, `out_valid <= 1`, and `acc <= 0`.
  - With `in_last` tied high, every beat produces one output (pure tree mode).
- Arithmetic: all additions are modulo 2^OUT_W. There is no saturation and no overflow flag. A group of up to 2^ACC_BITS beats cannot overflow.
- Global stall:
  - `stall = out_valid && !out_ready`.
  - While stalled, every pipeline register, `acc` and the output hold their values.
  - `in_ready = !stall`; this is combinational and carries no dependency on `in_valid`.
- Bubbles: a cycle with no accepted beat inserts valid=0 into level 1. Invalid stages never modify `acc`.
- Output register:
  - `out_valid` clears on acceptance unless a new last beat arrives in the same cycle.
  - When one does, `out_data` is replaced and `out_valid` stays 1 (back-to-back outputs).
- Reset (`rst_n`=0 at a rising edge):
  - All stage valid bits, `acc`, `out_data` and `out_valid` go to 0.
  - `in_ready` reads 1 in the cycle after reset.
  - Reset mid-operation discards every in-flight beat and any partial group; no output is emitted for them.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `in_ready`=1.
- Latency: a last beat accepted at edge t drives `out_valid`=1 after edge t+LEVELS+1, with no stall. Defaults: 5 cycles.
- Throughput: one beat per cycle while `out_ready`=1.
- Stall timing:
  - A stall asserted in cycle c freezes all stages at edge c.
  - `in_ready` is low in that same cycle c.
  - No beat is dropped or duplicated.
- Simultaneous events: in one cycle, an output accepted while the next last beat reaches the accumulate stage loads the new result with `out_valid` held at 1.

## Test plan
- Unsigned tree (`SIGNED`=0, `in_last`=1, all 12 lanes = 0xFF) -> `out_data` = 3060 (0x0BF4) five cycles after acceptance; then all lanes = 0 -> 0.
- Signed tree (`SIGNED`=1, all lanes = 0xFF, i.e. -1) -> `out_data` = 0xFFF4 (-12). Lanes = +127 ×6 and -128 ×6 -> 0xFFFA (-6).
- Accumulation: 3 beats with all lanes = 1, last on the third -> a single `out_valid` with `out_data` = 36. The next single-beat group with lanes = 2 -> 24, confirming `acc` was cleared.
- Backpressure:
  - Stimulus: 8 consecutive single-beat groups (lane0 = 1..8, other lanes 0), with `out_ready` low for 4 cycles mid-stream.
  - Required: outputs are exactly 1..8 in order, and `in_ready` is low only while `out_valid && !out_ready`.
- Bubbles: `in_valid` toggled every other cycle inside a 4-beat group (lanes = 3) -> one output of 144.
- Reset mid-group:
  - Stimulus: 2 beats of a group accepted, then `rst_n`=0 for one cycle, then a 1-beat group with lanes = 1.
  - Required: no output for the aborted group; the single output is 12.

Source files
------------

// File: rtl/pipelined_add_tree.sv
// Pipelined reduction adder: N_IN lanes summed through a registered binary tree,
// followed by a multi-beat accumulator closed by in_last, with valid/ready on both sides.
module pipelined_add_tree #(
  parameter int N_IN     = 12,
  parameter int IN_W     = 8,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [N_IN*IN_W-1:0]                      in_data,
  input  logic                                      in_valid,
  input  logic                                      in_last,
  output logic                                      in_ready,
  output logic [IN_W+$clog2(N_IN)+ACC_BITS-1:0]     out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int OUT_W  = IN_W + LEVELS + ACC_BITS;
  localparam int NPAD   = 2 ** LEVELS;
  localparam int NODES  = 2 * NPAD - 1;

  // Lane extension to the full output width before any addition.
  function automatic logic [OUT_W-1:0] ext_lane(input logic [IN_W-1:0] lane);
    logic fill;
    fill = (SIGNED != 0) ? lane[IN_W-1] : 1'b0;
    return {{(OUT_W-IN_W){fill}}, lane};
  endfunction

  logic                    stall_s;
  logic [OUT_W-1:0]        lane_s [NPAD];
  // Heap-ordered tree: node j has children 2j+1 and 2j+2; leaves occupy NPAD-1..NODES-1.
  logic [OUT_W-1:0]        node_r [NODES];
  logic [LEVELS:0]         stage_valid_r;
  logic [LEVELS:0]         stage_last_r;
  logic [OUT_W-1:0]        acc_r;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;

  for (genvar i = 0; i < NPAD; i++) begin : g_lane
    if (i < N_IN) begin : g_real
      assign lane_s[i] = ext_lane(in_data[i*IN_W +: IN_W]);
    end else begin : g_pad
      assign lane_s[i] = {OUT_W{1'b0}};
    end
  end

  // Tree pipeline: leaf registers capture lanes, each internal node adds its children.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NODES; j++) begin
        node_r[j] <= {OUT_W{1'b0}};
      end
      stage_valid_r <= {(LEVELS+1){1'b0}};
      stage_last_r  <= {(LEVELS+1){1'b0}};
    end else if (!stall_s) begin
      for (int i = 0; i < NPAD; i++) begin
        node_r[NPAD-1+i] <= lane_s[i];
      end
      for (int j = 0; j < NPAD-1; j++) begin
        node_r[j] <= node_r[2*j+1] + node_r[2*j+2];
      end
      stage_valid_r <= {stage_valid_r[LEVELS-1:0], in_valid};
      stage_last_r  <= {stage_last_r[LEVELS-1:0], in_last};
    end
  end

  // Accumulate stage and output register; an accepted output is replaced or cleared here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r     <= {OUT_W{1'b0}};
      out_data  <= {OUT_W{1'b0}};
      out_valid <= 1'b0;
    end else if (!stall_s) begin
      if (stage_valid_r[LEVELS]) begin
        if (stage_last_r[LEVELS]) begin
          out_data  <= acc_r + node_r[0];
          out_valid <= 1'b1;
          acc_r     <= {OUT_W{1'b0}};
        end else begin
          acc_r     <= acc_r + node_r[0];
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_tree.sv
// Self-checking bench: unsigned and signed instances share stimulus and are compared
// against a queue-based group-sum model.
module tb_pipelined_add_tree;

  localparam int N = 12;
  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic          in_ready_u, in_ready_s;
  logic [15:0]   out_data_u, out_data_s;
  logic          out_valid_u, out_valid_s;

  pipelined_add_tree #(.N_IN(N), .IN_W(W), .SIGNED(0), .ACC_BITS(4)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_u), .out_data(out_data_u), .out_valid(out_valid_u), .out_ready(out_ready)
  );

  pipelined_add_tree #(.N_IN(N), .IN_W(W), .SIGNED(1), .ACC_BITS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          acc_u = 0;
  int          acc_s = 0;
  logic [15:0] q_u[$];
  logic [15:0] q_s[$];
  bit          rand_ready = 1'b0;
  int          hold_ticks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a beat contributes the plain integer sum of its lanes to the group.
  task automatic model_beat(input logic [N*W-1:0] d, input logic last);
    logic [W-1:0] l;
    byte          b;
    for (int i = 0; i < N; i++) begin
      l = d[i*W +: W];
      b = l;
      acc_u += int'(l);
      acc_s += int'(b);
    end
    if (last) begin
      q_u.push_back(acc_u[15:0]);
      q_s.push_back(acc_s[15:0]);
      acc_u = 0;
      acc_s = 0;
    end
  endtask

  // One clock: choose out_ready, check handshake rules and any delivered output, advance.
  task automatic tick(output bit accepted);
    logic [15:0] eu, es;
    if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = (hold_ticks == 0);
      if (hold_ticks > 0) hold_ticks--;
    end
    #1;
    if (rst_n) begin
      chk("in_ready", {15'd0, in_ready_u}, {15'd0, !(out_valid_u && !out_ready)});
      chk("valid_pair", {15'd0, out_valid_s}, {15'd0, out_valid_u});
    end
    if (rst_n && out_valid_u && out_ready) begin
      n_vec++;
      assert (q_u.size() != 0) else begin
        n_err++;
        $error("FAIL spurious_out: observed %h expected no output", out_data_u);
      end
      if (q_u.size() != 0) begin
        eu = q_u.pop_front();
        es = q_s.pop_front();
        chk("sum_unsigned", out_data_u, eu);
        chk("sum_signed", out_data_s, es);
      end
      n_out++;
    end
    accepted = rst_n && in_valid && in_ready_u;
    if (!rst_n) begin
      acc_u = 0;
      acc_s = 0;
      q_u.delete();
      q_s.delete();
    end else if (accepted) begin
      model_beat(in_data, in_last);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [N*W-1:0] d, input logic last);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!a && n < 40) begin
      tick(a);
      n++;
    end
    n_vec++;
    assert (a) else begin
      n_err++;
      $error("FAIL beat_accept: observed %0d expected 1", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick(a);
  endtask

  // Idles until an output is presented; returns the wait in cycles.
  task automatic wait_out(input string tag, input logic [15:0] eu, input logic [15:0] es,
                          output int n);
    bit a;
    n = 0;
    in_valid = 1'b0;
    while (!out_valid_u && n < 40) begin
      tick(a);
      n++;
    end
    chk({tag, "_present"}, {15'd0, out_valid_u}, 16'd1);
    chk({tag, "_u"}, out_data_u, eu);
    chk({tag, "_s"}, out_data_s, es);
  endtask

  initial begin
    bit   a;
    int   n, outs0, len;
    logic [N*W-1:0] d;

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tick(a);
    tick(a);
    rst_n = 1'b1;
    #1;
    chk("rst_out_data", out_data_u, 16'h0000);
    chk("rst_out_valid", {15'd0, out_valid_u}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready_u}, 16'd1);

    // Pure tree mode with latency measurement.
    beat({N{8'hFF}}, 1'b1);
    wait_out("all_ff", 16'h0BF4, 16'hFFF4, n);
    chk("latency", n[15:0], 16'd5);
    beat({N*W{1'b0}}, 1'b1);
    wait_out("all_zero", 16'h0000, 16'h0000, n);
    beat({{6{8'h80}}, {6{8'h7F}}}, 1'b1);
    wait_out("mixed_sign", 16'd1530, 16'hFFFA, n);
    idle(2);

    // Accumulation across three beats, then a fresh group.
    outs0 = n_out;
    beat({N{8'h01}}, 1'b0);
    beat({N{8'h01}}, 1'b0);
    beat({N{8'h01}}, 1'b1);
    wait_out("accum3", 16'd36, 16'd36, n);
    idle(1);
    beat({N{8'h02}}, 1'b1);
    wait_out("acc_cleared", 16'd24, 16'd24, n);
    idle(1);
    chk("accum_out_count", 16'(n_out - outs0), 16'd2);

    // Backpressure mid-stream.
    outs0 = n_out;
    for (int k = 1; k <= 8; k++) begin
      d = '0;
      d[7:0] = 8'(k);
      beat(d, 1'b1);
      if (k == 6) hold_ticks = 4;
    end
    idle(15);
    chk("bp_out_count", 16'(n_out - outs0), 16'd8);

    // Bubbles inside one group.
    outs0 = n_out;
    for (int k = 0; k < 4; k++) begin
      beat({N{8'h03}}, (k == 3) ? 1'b1 : 1'b0);
      idle(1);
    end
    wait_out("bubbles", 16'd144, 16'd144, n);
    idle(2);
    chk("bubble_out_count", 16'(n_out - outs0), 16'd1);

    // Reset in the middle of a group.
    beat({N{8'h01}}, 1'b0);
    beat({N{8'h01}}, 1'b0);
    rst_n = 1'b0;
    tick(a);
    rst_n = 1'b1;
    outs0 = n_out;
    beat({N{8'h01}}, 1'b1);
    wait_out("after_reset", 16'd12, 16'd12, n);
    idle(8);
    chk("reset_out_count", 16'(n_out - outs0), 16'd1);

    // Randomized groups with random backpressure.
    rand_ready = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < N; i++) d[i*W +: W] = 8'($urandom);
        beat(d, (b == len - 1) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_ready = 1'b0;
    n = 0;
    while (q_u.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_empty", 16'(q_u.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
